line_fetch_ctrl: RTL and testbench
==================================

LINE_FETCH_CTRL -- requirements
Module: line_fetch_ctrl

Interface
REQ-001 Parameters: BASE_ADDR, default 32'h0000_0000, DDR byte address of input frame line 0.
REQ-002 Parameters: LINE_STRIDE, default 32'd8192, byte distance between consecutive input lines.
REQ-003 Parameters: PIX_DW, default 24, pixel data width.
REQ-004 Ports: vin_clk  in  1  sole clock; all logic posedge.
REQ-005 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Ports: frame_sync_n  in  1  synchronous frame restart, active-low.
REQ-007 Ports: vin_xres, vin_yres  in  16 each  input frame size in pixels / lines.
REQ-008 Ports: fetch_en  in  1  single-cycle line-pair request strobe.
REQ-009 Ports: fetch_line  in  16  upper source line of the requested pair.
REQ-010 Ports: ram_ready  out  1  level; both line buffers hold the requested pair.
REQ-011 Ports: rd_req  out  1, rd_addr  out  32, rd_len  out  16  DDR read burst request (rd_len in pixels).
REQ-012 Ports: rd_ack  in  1  request accepted; rd_dvalid  in  1, rd_data  in  PIX_DW  returned pixels, in order.
REQ-013 Ports: lbuf_we  out  1, lbuf_sel  out  1 (0 upper, 1 lower), lbuf_addr  out  16, lbuf_wdata  out  PIX_DW  line-buffer write port.

Function
REQ-014 FSM states: IDLE, REQ0, DATA0, REQ1, DATA1, READY; one-hot-free binary encoding.
REQ-015 IDLE/READY + fetch_en -> REQ0 next cycle; ram_ready deasserts the cycle after fetch_en is sampled.
REQ-016 fetch_en in REQ0..DATA1 ignored; no state, address or counter change.
REQ-017 Line clamp: L0 = min(fetch_line, vin_yres-1); L1 = min(L0+1, vin_yres-1); both latched on fetch_en.
REQ-018 rd_addr = BASE_ADDR + Ln*LINE_STRIDE, 32-bit modulo; rd_len = vin_xres.
REQ-019 rd_req rises the cycle after entry to REQ0/REQ1, holds with rd_addr/rd_len stable until rd_ack=1; ack cycle -> DATA0/DATA1, rd_req low next cycle.
REQ-020 DATA states: each rd_dvalid beat -> lbuf_we=1 one cycle later, lbuf_addr = beat index from 0, lbuf_sel = 0 (DATA0) / 1 (DATA1), lbuf_wdata = rd_data registered.
REQ-021 Beat vin_xres-1 ends state: DATA0 -> REQ1, DATA1 -> READY; rd_dvalid outside DATA states discarded.
REQ-022 ram_ready = 1 exactly while in READY; first assertion one cycle after final lbuf_we.
REQ-023 vin_xres = 0 or vin_yres = 0: fetch_en ignored, stays IDLE.
REQ-024 frame_sync_n = 0 any cycle: next cycle IDLE, rd_req 0, lbuf_we 0, ram_ready 0, beat counter 0; overrides fetch_en same cycle.

Reset
REQ-025 rst_n low asynchronously forces IDLE; ram_ready, rd_req, lbuf_we, lbuf_sel 0; rd_addr, rd_len, lbuf_addr, lbuf_wdata 0; cache tag invalid.
REQ-026 Release takes effect on first vin_clk edge with rst_n high; no request issued before a fetch_en.

Configuration
REQ-027 Macro LINE_PAIR_CACHE_EN defined: module stores last completed L0 with valid bit; fetch_en whose clamped L0 equals it -> READY next cycle, no DDR traffic, no lbuf writes.
REQ-028 Macro absent: every accepted fetch_en performs both reads; no tag storage.
REQ-029 Tag invalidated by frame_sync_n low and by reset.

Structure
REQ-030 Package vscale_pkg: FSM state typedef, PIX_DW default, 16-bit resolution width constant, 32-bit address width constant.
REQ-031 One sub-module line_addr_gen: clamp (REQ-017) and address multiply (REQ-018), registered, one-cycle latency absorbed in REQ0/REQ1 entry.

Verification
REQ-032 xres=8, yres=4, fetch_line=1, rd_ack immediate -> rd_addr 8192 then 16384, 8 lbuf writes sel0 addr0..7, 8 sel1, ram_ready 1 cycle after last write.
REQ-033 fetch_line=3, yres=4 -> L0=L1=3, both rd_addr 24576; fetch_line=9 -> same clamp.
REQ-034 rd_ack delayed 5 cycles -> rd_req held 5 cycles, rd_addr stable, one ack consumed per line.
REQ-035 frame_sync_n low during DATA0 beat 3 -> next cycle IDLE, no further lbuf_we, ram_ready stays 0; new fetch_en restarts from REQ0.
REQ-036 fetch_en pulse during DATA1 -> ignored, ram_ready timing unchanged; with LINE_PAIR_CACHE_EN, repeat fetch_line=1 -> ram_ready next cycle, rd_req never asserted.
REQ-037 rst_n low mid-DATA1 -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/vscale_pkg.sv
// Shared types and constants for the vertical-scaler line fetch path.
// The optional line-pair cache is enabled by defining LINE_PAIR_CACHE_EN.
package vscale_pkg;

    localparam int PIX_DW_DEF = 24;
    localparam int RES_W      = 16;
    localparam int ADDR_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_DATA0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_DATA1 = 3'd4,
        ST_READY = 3'd5
    } fetch_state_t;

    // Pin a requested line to the last line of the frame; yres must be non-zero.
    function automatic logic [RES_W-1:0] clamp_line(input logic [RES_W-1:0] line,
                                                    input logic [RES_W-1:0] yres);
        logic [RES_W-1:0] last;
        last = yres - 16'd1;
        return (line > last) ? last : line;
    endfunction

endpackage

// File: rtl/line_addr_gen.sv
// Clamps the requested upper line, derives the lower line, and registers
// the DDR byte address of both lines when a new fetch is accepted.
module line_addr_gen
    import vscale_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] LINE_STRIDE = 32'd8192
) (
    input  logic              vin_clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RES_W-1:0]  fetch_line,
    input  logic [RES_W-1:0]  yres,
    output logic [ADDR_W-1:0] addr0,
    output logic [ADDR_W-1:0] addr1
);

    logic [RES_W-1:0] l0_c;
    logic [RES_W-1:0] l1_c;

    // L0 <= yres-1 <= 65534, so L0+1 cannot wrap.
    assign l0_c = clamp_line(fetch_line, yres);
    assign l1_c = clamp_line(l0_c + 16'd1, yres);

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0 <= '0;
            addr1 <= '0;
        end else if (load) begin
            addr0 <= BASE_ADDR + ({{(ADDR_W-RES_W){1'b0}}, l0_c} * LINE_STRIDE);
            addr1 <= BASE_ADDR + ({{(ADDR_W-RES_W){1'b0}}, l1_c} * LINE_STRIDE);
        end
    end

endmodule

// File: rtl/line_fetch_ctrl.sv
// Fetches an upper/lower source line pair from DDR into two line buffers.
// Define LINE_PAIR_CACHE_EN to skip refetching a pair already held.
module line_fetch_ctrl
    import vscale_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] LINE_STRIDE = 32'd8192,
    parameter int                PIX_DW      = PIX_DW_DEF
) (
    input  logic              vin_clk,
    input  logic              rst_n,
    input  logic              frame_sync_n,
    input  logic [RES_W-1:0]  vin_xres,
    input  logic [RES_W-1:0]  vin_yres,
    input  logic              fetch_en,
    input  logic [RES_W-1:0]  fetch_line,
    output logic              ram_ready,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [RES_W-1:0]  rd_len,
    input  logic              rd_ack,
    input  logic              rd_dvalid,
    input  logic [PIX_DW-1:0] rd_data,
    output logic              lbuf_we,
    output logic              lbuf_sel,
    output logic [RES_W-1:0]  lbuf_addr,
    output logic [PIX_DW-1:0] lbuf_wdata,
    output logic [2:0]        dbg_state
);

    // Handshake: rd_req is held with rd_addr/rd_len stable until a cycle with
    // rd_ack=1, which is the transfer; rd_dvalid beats have no back-pressure.

    fetch_state_t     state_q, state_d;
    logic [RES_W-1:0] xres_q;
    logic [RES_W-1:0] beat_q;
    logic             done_q;
    logic [ADDR_W-1:0] addr0, addr1;

    logic accept, hit, load, req_state, ack_xfer, in_data, take, beat_last;

    assign accept    = fetch_en && frame_sync_n
                       && (state_q == ST_IDLE || state_q == ST_READY)
                       && (vin_xres != '0) && (vin_yres != '0);
    assign load      = accept && !hit;
    assign req_state = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign ack_xfer  = req_state && rd_req && rd_ack;
    assign in_data   = ((state_q == ST_DATA0) || (state_q == ST_DATA1)) && !done_q;
    assign take      = in_data && rd_dvalid;
    assign beat_last = (beat_q == xres_q - 16'd1);

    assign ram_ready = (state_q == ST_READY);
    assign dbg_state = state_q;

    line_addr_gen #(
        .BASE_ADDR   (BASE_ADDR),
        .LINE_STRIDE (LINE_STRIDE)
    ) u_addr_gen (
        .vin_clk    (vin_clk),
        .rst_n      (rst_n),
        .load       (load),
        .fetch_line (fetch_line),
        .yres       (vin_yres),
        .addr0      (addr0),
        .addr1      (addr1)
    );

`ifdef LINE_PAIR_CACHE_EN
    logic             tag_valid_q;
    logic [RES_W-1:0] tag_q;
    logic [RES_W-1:0] pend_l0_q;

    assign hit = accept && tag_valid_q && (clamp_line(fetch_line, vin_yres) == tag_q);

    // The tag is dropped as soon as a refetch starts overwriting the buffers.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            pend_l0_q   <= '0;
        end else if (!frame_sync_n) begin
            tag_valid_q <= 1'b0;
        end else if (load) begin
            tag_valid_q <= 1'b0;
            pend_l0_q   <= clamp_line(fetch_line, vin_yres);
        end else if (done_q) begin
            tag_valid_q <= 1'b1;
            tag_q       <= pend_l0_q;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_READY: if (accept) state_d = hit ? ST_READY : ST_REQ0;
            ST_REQ0:           if (ack_xfer) state_d = ST_DATA0;
            ST_DATA0:          if (take && beat_last) state_d = ST_REQ1;
            ST_REQ1:           if (ack_xfer) state_d = ST_DATA1;
            // Hold DATA1 one cycle past the last beat so READY follows the final write.
            ST_DATA1:          if (done_q) state_d = ST_READY;
            default:           state_d = ST_IDLE;
        endcase
        if (!frame_sync_n) state_d = ST_IDLE;
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            rd_len     <= '0;
            xres_q     <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            lbuf_we    <= 1'b0;
            lbuf_sel   <= 1'b0;
            lbuf_addr  <= '0;
            lbuf_wdata <= '0;
        end else if (!frame_sync_n) begin
            rd_req  <= 1'b0;
            lbuf_we <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (load) xres_q <= vin_xres;

            if (req_state) begin
                if (ack_xfer) begin
                    rd_req <= 1'b0;
                end else if (!rd_req) begin
                    rd_req  <= 1'b1;
                    rd_addr <= (state_q == ST_REQ0) ? addr0 : addr1;
                    rd_len  <= xres_q;
                end
            end else begin
                rd_req <= 1'b0;
            end

            lbuf_we <= take;
            if (take) begin
                lbuf_sel   <= (state_q == ST_DATA1);
                lbuf_addr  <= beat_q;
                lbuf_wdata <= rd_data;
                beat_q     <= beat_last ? '0 : beat_q + 16'd1;
            end
            done_q <= take && beat_last && (state_q == ST_DATA1);
        end
    end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Self-checking bench for line_fetch_ctrl with a DDR responder and a
// line-pair reference model; honours LINE_PAIR_CACHE_EN when defined.
module tb_line_fetch_ctrl;

    localparam int          PIX_DW = 24;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'd8192;
    localparam int          W      = 1 + 16 + PIX_DW;

    logic              vin_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_sync_n = 1'b1;
    logic [15:0]       vin_xres = 16'd8;
    logic [15:0]       vin_yres = 16'd4;
    logic              fetch_en = 1'b0;
    logic [15:0]       fetch_line = 16'd0;
    logic              ram_ready;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic [15:0]       rd_len;
    logic              rd_ack = 1'b0;
    logic              rd_dvalid = 1'b0;
    logic [PIX_DW-1:0] rd_data = '0;
    logic              lbuf_we;
    logic              lbuf_sel;
    logic [15:0]       lbuf_addr;
    logic [PIX_DW-1:0] lbuf_wdata;
    logic [2:0]        dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int req_rises = 0;
    bit prev_req = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_q[$];

`ifdef LINE_PAIR_CACHE_EN
    bit model_tag_valid = 1'b0;
    int model_tag = 0;
`endif

    line_fetch_ctrl #(
        .BASE_ADDR   (BASE),
        .LINE_STRIDE (STRIDE),
        .PIX_DW      (PIX_DW)
    ) dut (
        .vin_clk      (vin_clk),
        .rst_n        (rst_n),
        .frame_sync_n (frame_sync_n),
        .vin_xres     (vin_xres),
        .vin_yres     (vin_yres),
        .fetch_en     (fetch_en),
        .fetch_line   (fetch_line),
        .ram_ready    (ram_ready),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_dvalid    (rd_dvalid),
        .rd_data      (rd_data),
        .lbuf_we      (lbuf_we),
        .lbuf_sel     (lbuf_sel),
        .lbuf_addr    (lbuf_addr),
        .lbuf_wdata   (lbuf_wdata),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    always #5 vin_clk = ~vin_clk;
    always @(posedge vin_clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Capture line-buffer writes and request starts for the scenario tasks.
    always @(negedge vin_clk) begin
        if (lbuf_we === 1'b1) begin
            wr_q.push_back({lbuf_sel, lbuf_addr, lbuf_wdata});
            last_we_cyc = cyc;
        end
        if (rd_req === 1'b1 && !prev_req) req_rises++;
        prev_req = (rd_req === 1'b1);
    end

    function automatic bit model_hit(input int l0);
`ifdef LINE_PAIR_CACHE_EN
        return model_tag_valid && (model_tag == l0);
`else
        return (l0 < 0);
`endif
    endfunction

    task automatic model_invalidate();
`ifdef LINE_PAIR_CACHE_EN
        model_tag_valid = 1'b0;
`endif
    endtask

    // DDR responder for one line: accept the request, then stream xres beats.
    task automatic serve(input int k, input logic [31:0] exp_addr, input int xres,
                         input int ack_delay, input int poke_beat, output bit ok);
        int n;
        logic [PIX_DW-1:0] d;
        ok = 1'b1;
        n = 0;
        while (rd_req !== 1'b1 && n < 40) begin
            @(negedge vin_clk);
            n++;
        end
        checks++;
        if (rd_req !== 1'b1) begin
            failures++;
            $display("FAIL rd_req_timeout line%0d: rd_req=%b required 1", k, rd_req);
            ok = 1'b0;
            return;
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL rd_req_latency line%0d: got %0d cycles required 1", k, n);
        end
        checks++;
        if (rd_addr !== exp_addr) begin
            failures++;
            $display("FAIL rd_addr line%0d: got %0d required %0d", k, rd_addr, exp_addr);
        end
        checks++;
        if (rd_len !== 16'(xres)) begin
            failures++;
            $display("FAIL rd_len line%0d: got %0d required %0d", k, rd_len, xres);
        end
        // Stray beats while the request is pending must be discarded.
        for (int i = 0; i < ack_delay; i++) begin
            rd_dvalid = 1'b1;
            rd_data = PIX_DW'($urandom);
            @(negedge vin_clk);
            checks++;
            if (rd_req !== 1'b1 || rd_addr !== exp_addr) begin
                failures++;
                $display("FAIL rd_req_hold line%0d: rd_req=%b rd_addr=%0d required 1/%0d",
                         k, rd_req, rd_addr, exp_addr);
            end
        end
        rd_dvalid = 1'b0;
        rd_ack = 1'b1;
        @(negedge vin_clk);
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0) begin
            failures++;
            $display("FAIL rd_req_drop line%0d: rd_req=%b required 0", k, rd_req);
        end
        for (int b = 0; b < xres; b++) begin
            repeat ($urandom_range(0, 2)) begin
                rd_dvalid = 1'b0;
                @(negedge vin_clk);
            end
            d = PIX_DW'($urandom);
            rd_dvalid = 1'b1;
            rd_data = d;
            exp_q.push_back({1'(k), 16'(b), d});
            if (b == poke_beat) begin
                fetch_en = 1'b1;
                fetch_line = 16'd0;
            end
            @(negedge vin_clk);
            fetch_en = 1'b0;
        end
        rd_dvalid = 1'b0;
    endtask

    // Driver + checker for one complete line-pair request.
    task automatic do_fetch(input int line, input int xres, input int yres,
                            input int ack_delay, input int poke_beat);
        int l0, l1, n, r0;
        logic [31:0] a0, a1;
        bit ok;
        l0 = (line < yres) ? line : yres - 1;
        l1 = (l0 + 1 < yres) ? l0 + 1 : yres - 1;
        a0 = BASE + 32'(l0) * STRIDE;
        a1 = BASE + 32'(l1) * STRIDE;
        wr_q.delete();
        exp_q.delete();
        r0 = req_rises;
        vin_xres = 16'(xres);
        vin_yres = 16'(yres);
        fetch_line = 16'(line);
        fetch_en = 1'b1;
        @(negedge vin_clk);
        fetch_en = 1'b0;
        if (model_hit(l0)) begin
            checks++;
            if (ram_ready !== 1'b1) begin
                failures++;
                $display("FAIL cache_hit_ready L0=%0d: ram_ready=%b required 1", l0, ram_ready);
            end
            repeat (5) @(negedge vin_clk);
            checks++;
            if (req_rises != r0 || wr_q.size() != 0 || ram_ready !== 1'b1) begin
                failures++;
                $display("FAIL cache_hit_quiet L0=%0d: reqs=%0d writes=%0d ready=%b required 0/0/1",
                         l0, req_rises - r0, wr_q.size(), ram_ready);
            end
            return;
        end
        checks++;
        if (ram_ready !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_accept: ram_ready=%b rd_req=%b required 0/0", ram_ready, rd_req);
        end
        serve(0, a0, xres, ack_delay, -1, ok);
        if (ok) serve(1, a1, xres, ack_delay, poke_beat, ok);
        if (!ok) return;
        n = 0;
        while (ram_ready !== 1'b1 && n < 20) begin
            @(negedge vin_clk);
            n++;
        end
        checks++;
        if (ram_ready !== 1'b1) begin
            failures++;
            $display("FAIL ram_ready_timeout: ram_ready=%b required 1", ram_ready);
            return;
        end
        checks++;
        if (cyc != last_we_cyc + 1) begin
            failures++;
            $display("FAIL ram_ready_timing: rose cycle %0d required %0d", cyc, last_we_cyc + 1);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL lbuf_write_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lbuf_write[%0d]: got sel/addr/data %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
        repeat (3) @(negedge vin_clk);
        checks++;
        if (ram_ready !== 1'b1 || req_rises - r0 != 2) begin
            failures++;
            $display("FAIL ready_hold: ram_ready=%b requests=%0d required 1/2", ram_ready, req_rises - r0);
        end
`ifdef LINE_PAIR_CACHE_EN
        model_tag_valid = 1'b1;
        model_tag = l0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge vin_clk);
        checks++;
        if ({ram_ready, rd_req, lbuf_we, lbuf_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: ready/req/we/sel=%b required 0000", {ram_ready, rd_req, lbuf_we, lbuf_sel});
        end
        checks++;
        if (rd_addr !== '0 || rd_len !== '0 || lbuf_addr !== '0 || lbuf_wdata !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h len=%h laddr=%h wdata=%h required 0",
                     rd_addr, rd_len, lbuf_addr, lbuf_wdata);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge vin_clk);
        checks++;
        if (req_rises != 0 || ram_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: requests=%0d ram_ready=%b required 0/0", req_rises, ram_ready);
        end
    endtask

    task automatic test_basic();
        do_fetch(1, 8, 4, 0, -1);
    endtask

    task automatic test_clamp();
        do_fetch(3, 8, 4, 0, -1);
        do_fetch(9, 8, 4, 0, -1);
        do_fetch(0, 1, 1, 0, -1);
    endtask

    task automatic test_ack_delay();
        do_fetch(6, 5, 10, 5, -1);
    endtask

    task automatic test_zero_res();
        int r0;
        r0 = req_rises;
        vin_xres = 16'd0;
        vin_yres = 16'd4;
        fetch_line = 16'd2;
        fetch_en = 1'b1;
        @(negedge vin_clk);
        fetch_en = 1'b0;
        repeat (4) @(negedge vin_clk);
        checks++;
        if (ram_ready !== 1'b1 || req_rises != r0) begin
            failures++;
            $display("FAIL zero_xres: ram_ready=%b requests=%0d required 1/0", ram_ready, req_rises - r0);
        end
        vin_xres = 16'd8;
        vin_yres = 16'd0;
        fetch_en = 1'b1;
        @(negedge vin_clk);
        fetch_en = 1'b0;
        repeat (4) @(negedge vin_clk);
        checks++;
        if (ram_ready !== 1'b1 || req_rises != r0) begin
            failures++;
            $display("FAIL zero_yres: ram_ready=%b requests=%0d required 1/0", ram_ready, req_rises - r0);
        end
    endtask

    task automatic test_frame_sync();
        int n, r0;
        vin_xres = 16'd8;
        vin_yres = 16'd4;
        fetch_line = 16'd2;
        fetch_en = 1'b1;
        @(negedge vin_clk);
        fetch_en = 1'b0;
        n = 0;
        while (rd_req !== 1'b1 && n < 40) begin
            @(negedge vin_clk);
            n++;
        end
        rd_ack = 1'b1;
        @(negedge vin_clk);
        rd_ack = 1'b0;
        wr_q.delete();
        for (int b = 0; b < 3; b++) begin
            rd_dvalid = 1'b1;
            rd_data = PIX_DW'($urandom);
            @(negedge vin_clk);
        end
        // Beat 3 arrives with the frame restart and a competing fetch strobe.
        r0 = req_rises;
        rd_dvalid = 1'b1;
        frame_sync_n = 1'b0;
        fetch_en = 1'b1;
        @(negedge vin_clk);
        frame_sync_n = 1'b1;
        fetch_en = 1'b0;
        model_invalidate();
        checks++;
        if (rd_req !== 1'b0 || lbuf_we !== 1'b0 || ram_ready !== 1'b0) begin
            failures++;
            $display("FAIL frame_sync_abort: req/we/ready=%b%b%b required 000", rd_req, lbuf_we, ram_ready);
        end
        repeat (4) begin
            rd_data = PIX_DW'($urandom);
            @(negedge vin_clk);
        end
        rd_dvalid = 1'b0;
        repeat (2) @(negedge vin_clk);
        checks++;
        if (wr_q.size() != 3 || req_rises != r0 || ram_ready !== 1'b0) begin
            failures++;
            $display("FAIL frame_sync_quiet: writes=%0d requests=%0d ready=%b required 3/0/0",
                     wr_q.size(), req_rises - r0, ram_ready);
        end
        do_fetch(2, 8, 4, 0, -1);
    endtask

    task automatic test_fetch_during_data1();
        do_fetch(1, 8, 4, 1, 3);
        do_fetch(1, 8, 4, 0, -1);
    endtask

    task automatic test_random();
        int x, y, l, d;
        for (int i = 0; i < 8; i++) begin
            x = $urandom_range(1, 10);
            y = $urandom_range(1, 20);
            l = $urandom_range(0, 24);
            d = $urandom_range(0, 3);
            do_fetch(l, x, y, d, -1);
        end
    endtask

    task automatic test_reset_mid();
        int n, r0;
        bit ok;
        vin_xres = 16'd6;
        vin_yres = 16'd10;
        fetch_line = 16'd4;
        fetch_en = 1'b1;
        @(negedge vin_clk);
        fetch_en = 1'b0;
        exp_q.delete();
        serve(0, BASE + 32'd4 * STRIDE, 6, 0, -1, ok);
        if (!ok) return;
        n = 0;
        while (rd_req !== 1'b1 && n < 40) begin
            @(negedge vin_clk);
            n++;
        end
        rd_ack = 1'b1;
        @(negedge vin_clk);
        rd_ack = 1'b0;
        rd_dvalid = 1'b1;
        rd_data = 24'hA55AC3;
        repeat (2) @(negedge vin_clk);
        rd_dvalid = 1'b0;
        // Assert reset between clock edges; outputs must clear without one.
        #2 rst_n = 1'b0;
        #1;
        model_invalidate();
        checks++;
        if ({ram_ready, rd_req, lbuf_we, lbuf_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_ctrl: ready/req/we/sel=%b required 0000", {ram_ready, rd_req, lbuf_we, lbuf_sel});
        end
        checks++;
        if (rd_addr !== '0 || rd_len !== '0 || lbuf_addr !== '0 || lbuf_wdata !== '0) begin
            failures++;
            $display("FAIL async_reset_data: addr=%h len=%h laddr=%h wdata=%h required 0",
                     rd_addr, rd_len, lbuf_addr, lbuf_wdata);
        end
        @(negedge vin_clk);
        rst_n = 1'b1;
        r0 = req_rises;
        repeat (4) @(negedge vin_clk);
        checks++;
        if (req_rises != r0 || ram_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_async_reset: requests=%0d ready=%b required 0/0", req_rises - r0, ram_ready);
        end
        do_fetch(4, 6, 10, 2, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_ack_delay();
        test_zero_res();
        test_frame_sync();
        test_fetch_during_data1();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
